// File: rtl/nf_clock_div_pkg.sv
// Shared types and defaults for the multi-channel enable-strobe divider.
// Mode decode helpers keep the reserved encoding folded into HALT in one place.
package nf_clock_div_pkg;

  typedef enum logic [1:0] {
    NF_DIV_HALT = 2'b00,
    NF_DIV_RUN  = 2'b01,
    NF_DIV_STEP = 2'b10,
    NF_DIV_RSVD = 2'b11
  } nf_div_mode_t;

  localparam int NF_DIV_CH_DEFAULT = 2;
  localparam int NF_DIV_W_DEFAULT  = 26;

  function automatic logic mode_is_run(input nf_div_mode_t m);
    return (m == NF_DIV_RUN);
  endfunction

  function automatic logic mode_is_step(input nf_div_mode_t m);
    return (m == NF_DIV_STEP);
  endfunction

endpackage

// File: rtl/nf_clock_div_mc_if.sv
// Control/strobe bundle for nf_clock_div_mc; all channel fields are flattened buses.
// No valid/ready: inputs are levels sampled every rising clk edge, en/busy are registered.
interface nf_clock_div_mc_if #(
  parameter int CH    = 2,
  parameter int DIV_W = 26
) ();

  logic                  sync;
  logic [CH*DIV_W-1:0]   div;
  logic [CH*2-1:0]       mode;
  logic [CH-1:0]         step_req;
  logic [CH-1:0]         en;
  logic [CH-1:0]         busy;

  modport master (
    output sync,
    output div,
    output mode,
    output step_req,
    input  en,
    input  busy
  );

  modport slave (
    input  sync,
    input  div,
    input  mode,
    input  step_req,
    output en,
    output busy
  );

endinterface

// File: rtl/nf_clock_div_ch.sv
// One strobe channel: period counter, step_req edge detector, registered en/busy.
// HALT (and the reserved mode) freeze the counter so RUN resumes with the same phase.
module nf_clock_div_ch
  import nf_clock_div_pkg::*;
#(
  parameter int DIV_W = NF_DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             step_req,
  output logic             en,
  output logic             busy
);

  nf_div_mode_t     mode_e;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             step_prev_q, step_prev_d;
  logic             step_rise;

  assign mode_e    = nf_div_mode_t'(mode);
  assign step_rise = step_req & ~step_prev_q;

  always_comb begin
    cnt_d       = cnt_q;
    en_d        = 1'b0;
    busy_d      = mode_is_run(mode_e);
    step_prev_d = step_req;

    if (sync) begin
      cnt_d = '0;
    end else if (mode_is_run(mode_e)) begin
      // >= so that shrinking div below the running count fires immediately.
      if (cnt_q >= div) begin
        en_d  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else if (mode_is_step(mode_e)) begin
      cnt_d = '0;
      en_d  = step_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign en   = en_q;
  assign busy = busy_q;

endmodule

// File: rtl/nf_clock_div_mc.sv
// CH independent enable-strobe channels sharing clk, reset and sync.
// Channel 0 is intended for the CPU enable; the rest serve peripherals or debug stepping.
module nf_clock_div_mc
  import nf_clock_div_pkg::*;
#(
  parameter int CH    = NF_DIV_CH_DEFAULT,
  parameter int DIV_W = NF_DIV_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  nf_clock_div_mc_if.slave     bus
);

  logic [CH-1:0] en_w;
  logic [CH-1:0] busy_w;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    nf_clock_div_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .sync     (bus.sync),
      .div      (bus.div[i*DIV_W +: DIV_W]),
      .mode     (bus.mode[i*2 +: 2]),
      .step_req (bus.step_req[i]),
      .en       (en_w[i]),
      .busy     (busy_w[i])
    );
  end

  assign bus.en   = en_w;
  assign bus.busy = busy_w;

endmodule

// File: tb/tb_nf_clock_div_mc.sv
// Directed bench for nf_clock_div_mc: per-cycle model scoreboard plus literal pulse-timing checks.
module tb_nf_clock_div_mc;

  localparam int CH = 2;
  localparam int DW = 26;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nf_clock_div_mc_if #(.CH(CH), .DIV_W(DW)) ifc ();

  nf_clock_div_mc #(.CH(CH), .DIV_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // Each channel tracks "cycles elapsed since its last strobe" as a plain integer.
  int               m_phase [CH];
  bit               m_prev  [CH];
  logic [2*CH-1:0]  exp_q[$];

  always @(posedge clk) begin
    logic [CH-1:0] e_en, e_busy;
    int md, dv;
    bit sreq;
    e_en   = '0;
    e_busy = '0;
    for (int i = 0; i < CH; i++) begin
      md   = int'(ifc.mode[i*2 +: 2]);
      dv   = int'(ifc.div[i*DW +: DW]);
      sreq = ifc.step_req[i];
      if (reset) begin
        m_phase[i] = 0;
        m_prev[i]  = 0;
      end else begin
        e_busy[i] = (md == 1);
        if (ifc.sync) begin
          m_phase[i] = 0;
        end else if (md == 1) begin
          if (m_phase[i] >= dv) begin
            e_en[i]    = 1'b1;
            m_phase[i] = 0;
          end else begin
            m_phase[i] = m_phase[i] + 1;
          end
        end else if (md == 2) begin
          m_phase[i] = 0;
          e_en[i]    = sreq && !m_prev[i];
        end
        m_prev[i] = sreq;
      end
    end
    exp_q.push_back({e_busy, e_en});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [2*CH-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({ifc.busy, ifc.en} !== e) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t busy_en got=%b exp=%b", $time, {ifc.busy, ifc.en}, e);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int ch, input logic [1:0] md, input int dv);
    ifc.mode[ch*2 +: 2] = md;
    ifc.div[ch*DW +: DW] = DW'(dv);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic pulse_sync();
    ifc.sync = 1'b1;
    @(negedge clk);
    ifc.sync = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first0, first1, cnt0, cnt1, both, second0;

    reset        = 1'b1;
    ifc.sync     = 1'b0;
    ifc.div      = '0;
    ifc.mode     = '0;
    ifc.step_req = '0;
    tick(2);
    check("reset_en", int'(ifc.en), 0);
    check("reset_busy", int'(ifc.busy), 0);

    // ch0 RUN div=3 for 40 edges
    reset = 1'b0;
    set_ch(0, 2'b01, 3);
    first0 = -1; cnt0 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) check("t1_busy_edge1", int'(ifc.busy[0]), 1);
      if (ifc.en[0]) begin
        cnt0++;
        if (first0 < 0) first0 = k;
      end
    end
    check("t1_first_pulse", first0, 4);
    check("t1_pulse_count", cnt0, 10);

    // div=0 continuous, then reserved/HALT holds phase
    set_ch(0, 2'b01, 0);
    cnt0 = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (ifc.en[0]) cnt0++;
    end
    check("t2_div0_count", cnt0, 5);
    set_ch(0, 2'b00, 0);
    tick(1);
    check("t2_halt_en", int'(ifc.en[0]), 0);
    check("t2_halt_busy", int'(ifc.busy[0]), 0);
    set_ch(0, 2'b01, 3);
    tick(2);
    set_ch(0, 2'b11, 3);
    tick(5);
    check("t2_rsvd_busy", int'(ifc.busy[0]), 0);
    set_ch(0, 2'b01, 3);
    first0 = -1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (ifc.en[0] && first0 < 0) first0 = k;
    end
    check("t2_resume_first", first0, 2);
    set_ch(0, 2'b00, 3);

    // ch1 STEP
    set_ch(1, 2'b10, 0);
    tick(2);
    ifc.step_req[1] = 1'b1;
    first1 = -1; cnt1 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ifc.en[1]) begin
        cnt1++;
        if (first1 < 0) first1 = k;
      end
    end
    check("t3_held_count", cnt1, 1);
    check("t3_held_first", first1, 1);
    cnt1 = 0;
    for (int r = 0; r < 3; r++) begin
      ifc.step_req[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin @(negedge clk); if (ifc.en[1]) cnt1++; end
      ifc.step_req[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin @(negedge clk); if (ifc.en[1]) cnt1++; end
    end
    check("t3_three_edges", cnt1, 3);
    cnt1 = 0;
    for (int j = 0; j < 8; j++) begin
      ifc.step_req[1] = (j % 2 == 1);
      @(negedge clk);
      if (ifc.en[1]) cnt1++;
    end
    check("t3_toggle_count", cnt1, 4);
    ifc.step_req[1] = 1'b0;
    tick(1);
    set_ch(1, 2'b00, 0);
    ifc.step_req[1] = 1'b1;
    tick(1);
    set_ch(1, 2'b10, 0);
    cnt1 = 0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (ifc.en[1]) cnt1++; end
    check("t3_stale_edge", cnt1, 0);
    ifc.step_req[1] = 1'b0;
    set_ch(1, 2'b00, 0);

    // ch0 div 9 -> 4 at count 7
    set_ch(0, 2'b01, 9);
    pulse_sync();
    first0 = -1; second0 = -1; cnt0 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifc.en[0]) begin
        cnt0++;
        if (first0 < 0) first0 = k;
        else if (second0 < 0) second0 = k;
      end
      if (k == 7) set_ch(0, 2'b01, 4);
    end
    check("t4_first", first0, 8);
    check("t4_second", second0, 13);
    check("t4_count", cnt0, 3);

    // both RUN, sync alignment
    set_ch(0, 2'b01, 3);
    set_ch(1, 2'b01, 5);
    pulse_sync();
    first0 = -1; first1 = -1; cnt0 = 0; cnt1 = 0; both = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (ifc.en[0]) begin cnt0++; if (first0 < 0) first0 = k; end
      if (ifc.en[1]) begin cnt1++; if (first1 < 0) first1 = k; end
      if (ifc.en[0] && ifc.en[1]) both++;
    end
    check("t5_first0", first0, 4);
    check("t5_first1", first1, 6);
    check("t5_count0", cnt0, 6);
    check("t5_count1", cnt1, 4);
    check("t5_coincide", both, 2);

    // reset mid-RUN at count 2
    pulse_sync();
    tick(2);
    reset = 1'b1;
    tick(1);
    check("t6_reset_en", int'(ifc.en), 0);
    check("t6_reset_busy", int'(ifc.busy), 0);
    reset = 1'b0;
    first0 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ifc.en[0] && first0 < 0) first0 = k;
    end
    check("t6_first_after_reset", first0, 4);

    set_ch(0, 2'b00, 0);
    set_ch(1, 2'b00, 0);
    tick(3);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
